// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction / data) arbiter onto a single shared
// memory port with a fixed access latency.
// Optional feature: define ARB_RR_EN for round-robin contention resolution;
// without it the data side always wins simultaneous requests.
module mem_arbiter #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t             state, state_next;
    owner_t             owner, last_winner;
    logic [3:0]         cnt;
    logic [ADDR_W-1:0]  lat_addr;
    logic               lat_wr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [DATA_W-1:0]  i_rdata_r, d_rdata_r;
    logic               pick_d;
    logic               accept;

    // Contention policy: decide whether the data side wins this cycle
    always_comb begin
        pick_d = 1'b0;
`ifdef ARB_RR_EN
        pick_d = d_req && (!i_req || (last_winner == OWN_I));
`else
        pick_d = d_req;
`endif
    end

    // Next-state and output decode
    always_comb begin
        state_next  = state;
        i_grant     = 1'b0;
        d_grant     = 1'b0;
        i_valid     = 1'b0;
        d_valid     = 1'b0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                // Grants are suppressed while reset is held since nothing would be latched
                if (!rst && (i_req || d_req)) begin
                    accept     = 1'b1;
                    d_grant    = pick_d;
                    i_grant    = !pick_d;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_enable = 1'b1;
                mem_wr     = lat_wr;
                if (cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                i_valid    = (owner == OWN_I);
                d_valid    = (owner == OWN_D);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, request latches, latency counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_I;
            last_winner <= OWN_I;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_wr      <= 1'b0;
            lat_wdata   <= '0;
            i_rdata_r   <= '0;
            d_rdata_r   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= 4'(LATENCY);
                if (pick_d) begin
                    owner       <= OWN_D;
                    last_winner <= OWN_D;
                    lat_addr    <= d_addr;
                    lat_wr      <= d_wr;
                    lat_wdata   <= d_wdata;
                end else begin
                    owner       <= OWN_I;
                    last_winner <= OWN_I;
                    lat_addr    <= i_addr;
                    lat_wr      <= 1'b0;
                    lat_wdata   <= '0;
                end
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (owner == OWN_I) begin
                        i_rdata_r <= mem_data_out;
                    end else if (!lat_wr) begin
                        d_rdata_r <= mem_data_out;
                    end
                end
            end
        end
    end

    assign mem_addr    = lat_addr;
    assign mem_data_in = lat_wdata;
    assign i_rdata     = i_rdata_r;
    assign d_rdata     = d_rdata_r;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (LATENCY=4).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, i_valid, d_grant, d_valid;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_enable, mem_wr, busy;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;

    int compared   = 0;
    int mismatched = 0;

    mem_arbiter #(.LATENCY(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: fixed word at 0x0010, address XOR pattern elsewhere
    assign mem_data_out = (mem_addr == 16'h0010) ? 16'hBEEF : (mem_addr ^ 16'hA5A5);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {i_grant, d_grant, i_valid, d_valid, mem_enable, mem_wr, busy}
    function automatic logic [6:0] ctl();
        return {i_grant, d_grant, i_valid, d_valid, mem_enable, mem_wr, busy};
    endfunction

    logic exp_d;

    initial begin
        rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        tick; tick;
        #1;
        check("reset_ctl", {25'd0, ctl()}, 32'd0);
        check("reset_bus", {mem_addr, mem_data_in}, 32'd0);
        check("reset_rdata", {i_rdata, d_rdata}, 32'd0);
        rst = 1'b0;
        tick;

        // Single load
        d_req = 1; d_wr = 0; d_addr = 16'h0010; #1;
        check("load_grant", {25'd0, ctl()}, {25'd0, 7'b0100000});
        for (int k = 1; k <= 4; k++) begin
            tick;
            d_req = 0; #1;
            check("load_access_ctl", {25'd0, ctl()}, {25'd0, 7'b0000101});
            check("load_access_addr", {16'd0, mem_addr}, 32'h0010);
        end
        tick;
        check("load_valid", {25'd0, ctl()}, {25'd0, 7'b0001001});
        check("load_rdata", {16'd0, d_rdata}, 32'hBEEF);
        tick;
        check("load_idle", {25'd0, ctl()}, 32'd0);

        // Store
        d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234; #1;
        check("store_grant", {25'd0, ctl()}, {25'd0, 7'b0100000});
        for (int k = 1; k <= 4; k++) begin
            tick;
            d_req = 0; #1;
            check("store_access_ctl", {25'd0, ctl()}, {25'd0, 7'b0000111});
            check("store_access_bus", {mem_addr, mem_data_in}, 32'h0020_1234);
        end
        tick;
        check("store_valid", {25'd0, ctl()}, {25'd0, 7'b0001001});
        check("store_rdata_kept", {16'd0, d_rdata}, 32'hBEEF);
        tick;
        d_wr = 0;

        // Fetch with request dropped after grant
        i_req = 1; i_addr = 16'h0030; #1;
        check("fetch_grant", {25'd0, ctl()}, {25'd0, 7'b1000000});
        tick;
        i_req = 0; #1;
        check("fetch_access", {25'd0, ctl()}, {25'd0, 7'b0000101});
        check("fetch_addr", {16'd0, mem_addr}, 32'h0030);
        tick; tick; tick; tick;
        check("fetch_valid", {25'd0, ctl()}, {25'd0, 7'b0010001});
        check("fetch_rdata", {16'd0, i_rdata}, 32'hA595);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("fetch_no_regrant", {25'd0, ctl()}, 32'd0);
        end

        // Reset in the middle of a fetch
        i_req = 1; i_addr = 16'h0040; #1;
        check("abort_grant", {31'd0, i_grant}, 32'd1);
        tick;
        i_req = 0;
        tick;
        rst = 1; #1;
        check("abort_pre_reset", {31'd0, mem_enable}, 32'd1);
        tick;
        rst = 0; #1;
        check("abort_after_reset", {25'd0, ctl()}, 32'd0);
        check("abort_rdata_cleared", {i_rdata, d_rdata}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick;
            check("abort_no_valid", {30'd0, i_valid, d_valid}, 32'd0);
        end

        // Contention from reset release
        rst = 1; i_req = 1; d_req = 1; d_wr = 0; i_addr = 16'h0050; d_addr = 16'h0060; #1;
        check("contend_no_grant_in_reset", {30'd0, i_grant, d_grant}, 32'd0);
        tick;
        rst = 0; #1;
        exp_d = 1'b1;
        for (int g = 0; g < 3; g++) begin
            check("contend_grant", {30'd0, i_grant, d_grant}, {30'd0, !exp_d, exp_d});
            for (int k = 1; k <= 5; k++) begin
                tick;
                check("contend_gap_no_grant", {30'd0, i_grant, d_grant}, 32'd0);
            end
            check("contend_valid", {30'd0, i_valid, d_valid}, {30'd0, !exp_d, exp_d});
            if (exp_d)
                check("contend_d_rdata", {16'd0, d_rdata}, 32'hA5C5);
            else
                check("contend_i_rdata", {16'd0, i_rdata}, 32'hA5F5);
            tick;
`ifdef ARB_RR_EN
            exp_d = !exp_d;
`endif
        end
        i_req = 0; d_req = 0; #1;
        check("contend_end_idle", {25'd0, ctl()}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, memory cycles per access (legal range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter DATA_W, default 16, data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_req  input  1  instruction-fetch request; level-held until i_grant.
REQ-007 SHALL have port i_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port i_grant  output  1  one-cycle pulse when the fetch is accepted.
REQ-009 SHALL have port i_valid  output  1  one-cycle pulse when i_rdata is updated.
REQ-010 SHALL have port i_rdata  output  DATA_W  fetched word.
REQ-011 SHALL have port d_req  input  1  data request; level-held until d_grant.
REQ-012 SHALL have port d_wr  input  1  1 = store, 0 = load.
REQ-013 SHALL have port d_addr  input  ADDR_W  data address.
REQ-014 SHALL have port d_wdata  input  DATA_W  store data.
REQ-015 SHALL have port d_grant  output  1  one-cycle acceptance pulse.
REQ-016 SHALL have port d_valid  output  1  one-cycle completion pulse, for loads and stores.
REQ-017 SHALL have port d_rdata  output  DATA_W  loaded word.
REQ-018 SHALL have ports mem_enable, mem_wr (output 1), mem_addr (output ADDR_W), mem_data_in (output DATA_W), mem_data_out (input DATA_W), the single shared memory port.
REQ-019 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-021 IDLE: if any request is pending, assert the winner's grant, latch addr/wr/wdata/owner, load the counter with LATENCY, and go to ACCESS; otherwise stay in IDLE.
REQ-022 ACCESS: drive mem_enable=1, mem_wr=latched wr (always 0 for I-side), mem_addr and mem_data_in from the latches, and decrement the counter each cycle.
REQ-023 ACCESS: on the cycle the counter reads 1, capture mem_data_out into the owner's rdata register (loads only) and go to DONE.
REQ-024 DONE: pulse the owner's valid for one cycle, then go to IDLE.
REQ-025 Latency from grant cycle T: mem_enable high T+1..T+LATENCY; valid at T+LATENCY+1; next grant no earlier than T+LATENCY+2.
REQ-026 Outside ACCESS, mem_enable and mem_wr SHALL be 0.
REQ-027 When one requester is pending it SHALL be granted; simultaneous requests SHALL be resolved per REQ-035/036.
REQ-028 Deassertion of req after grant SHALL NOT abort the transaction; a new request arriving outside IDLE SHALL wait.
REQ-029 i_rdata/d_rdata SHALL hold their last value until that port's next load completes; stores leave d_rdata unchanged.
REQ-030 Grant and valid outputs SHALL never be asserted for both ports in the same cycle.

Reset
REQ-031 On a clock edge with rst=1: FSM to IDLE, counter 0, latches 0, owner/last-winner = I.
REQ-032 After reset: all grant/valid/mem_enable/mem_wr/busy = 0, mem_addr/mem_data_in = 0, i_rdata = d_rdata = 0.
REQ-033 Reset during ACCESS or DONE SHALL abort the transaction with no valid pulse; mem_enable low in the cycle after the reset edge.

Configuration
REQ-034 Macro ARB_RR_EN SHALL select the contention policy.
REQ-035 Without ARB_RR_EN: fixed priority, D-side wins every simultaneous request.
REQ-036 With ARB_RR_EN: the requester not granted last wins contention; last-winner updates on each grant (reset value I, so D wins the first contention).

Verification
REQ-037 Single load: d_req=1, d_wr=0, d_addr=0x0010, mem returns 0xBEEF -> d_grant at T, mem_enable T+1..T+4, d_valid at T+5, d_rdata=0xBEEF.
REQ-038 Store: d_wr=1, d_addr=0x0020, d_wdata=0x1234 -> mem_wr=1 with mem_addr=0x0020 and mem_data_in=0x1234 for 4 cycles; d_valid at T+5; d_rdata unchanged.
REQ-039 Contention: i_req and d_req both held from reset release -> without macro D,D,D...; with ARB_RR_EN D,I,D,I alternating; grants 6 cycles apart.
REQ-040 Reset mid-access: assert rst at T+2 of a fetch -> no i_valid, mem_enable=0 at T+3, busy=0.
REQ-041 Early drop: i_req deasserted at T+1 -> fetch still completes, i_valid at T+5, no second grant.
